// File: rtl/sseg_s2p_rx.sv
// sseg_s2p_rx: serial-to-parallel receiver for the seven-segment display link.
// It rebuilds the 64-bit segment frame from seg_clk/seg_sout/seg_clrn/SEG_PEN.
// It also decodes each frame byte back to a hex nibble and a decimal point.
// Optional feature macro: SSEG_RX_DECODE_EN
//   defined   - decode outputs (hex, points, blank, decode_err) are built.
//   undefined - decode outputs are tied to 0.
module sseg_s2p_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_clk,
  input  logic        seg_clrn,
  input  logic        SEG_PEN,
  input  logic        seg_sout,
  output logic [63:0] frame,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [31:0] hex,
  output logic [7:0]  points,
  output logic [7:0]  blank,
  output logic [7:0]  decode_err
);

  // Synchronizer lane order: {pen, clrn, sout, sclk}.
  // The control lines idle high, so the pen and clrn lanes reset to 1.
  // This keeps a reset release from looking like a SEG_PEN rising edge.
  localparam logic [3:0] SYNC_RST  = 4'b1100;
  localparam logic [6:0] CNT_FULL  = 7'd64;
  localparam logic [6:0] CNT_SAT   = 7'd65;

  logic [3:0]  raw_in;
  logic [3:0]  sync_q [SYNC_STAGES];
  logic [3:0]  sync_d [SYNC_STAGES];

  logic        sclk_s;
  logic        sout_s;
  logic        clrn_s;
  logic        pen_s;
  logic        sclk_prev_q;
  logic        pen_prev_q;
  logic        sclk_rise;
  logic        pen_rise;

  logic [63:0] shreg_q;
  logic [63:0] shreg_d;
  logic [6:0]  cnt_q;
  logic [6:0]  cnt_d;
  logic [63:0] frame_q;
  logic [63:0] frame_d;
  logic        frame_valid_q;
  logic        frame_valid_d;
  logic        frame_err_q;
  logic        frame_err_d;

  assign raw_in = {SEG_PEN, seg_clrn, seg_sout, seg_clk};

  // Synchronizer chain: stage 0 takes the pins, each later stage takes the previous one.
  always_comb begin
    sync_d[0] = raw_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= SYNC_RST;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign sclk_s = sync_q[SYNC_STAGES-1][0];
  assign sout_s = sync_q[SYNC_STAGES-1][1];
  assign clrn_s = sync_q[SYNC_STAGES-1][2];
  assign pen_s  = sync_q[SYNC_STAGES-1][3];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign pen_rise  = pen_s & ~pen_prev_q;

  // Shift, clear and commit.
  // A shift and a SEG_PEN rise on the same cycle apply the shift first.
  // A clear on the same cycle as a SEG_PEN rise wins, so the zero count reports an error.
  always_comb begin
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    if (!clrn_s) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (sclk_rise && (!pen_s || pen_rise)) begin
      shreg_d = {shreg_q[62:0], sout_s};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 7'd1;
      end
    end
    if (pen_rise) begin
      if (cnt_d == CNT_FULL) begin
        frame_d       = shreg_d;
        frame_valid_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
      cnt_d = '0;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_prev_q   <= 1'b0;
      pen_prev_q    <= 1'b1;
      shreg_q       <= '0;
      cnt_q         <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sclk_prev_q   <= sclk_s;
      pen_prev_q    <= pen_s;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

`ifdef SSEG_RX_DECODE_EN
  // Active-high g..a pattern for each hex value.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Decodes one active-low byte into {decode_err, blank, point, nibble}.
  function automatic logic [6:0] decode_byte(input logic [7:0] b);
    logic [6:0] seg;
    logic [3:0] nib;
    logic       bl;
    logic       er;
    logic       hit;
    seg = ~b[6:0];
    nib = 4'h0;
    bl  = 1'b0;
    er  = 1'b0;
    hit = 1'b0;
    if (seg == 7'h00) begin
      bl = 1'b1;
    end else begin
      for (int n = 0; n < 16; n++) begin
        if (!hit && seg == glyph(4'(n))) begin
          nib = 4'(n);
          hit = 1'b1;
        end
      end
      er = ~hit;
    end
    return {er, bl, ~b[7], nib};
  endfunction

  logic [6:0]  dec_w [8];
  logic [31:0] hex_q;
  logic [31:0] hex_d;
  logic [7:0]  points_q;
  logic [7:0]  points_d;
  logic [7:0]  blank_q;
  logic [7:0]  blank_d;
  logic [7:0]  derr_q;
  logic [7:0]  derr_d;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_digit
    assign dec_w[gi] = decode_byte(frame_d[8*gi +: 8]);
  end

  // Decode outputs load only when a frame commits, so they change with frame_valid.
  always_comb begin
    hex_d    = hex_q;
    points_d = points_q;
    blank_d  = blank_q;
    derr_d   = derr_q;
    if (frame_valid_d) begin
      for (int i = 0; i < 8; i++) begin
        hex_d[4*i +: 4] = dec_w[i][3:0];
        points_d[i]     = dec_w[i][4];
        blank_d[i]      = dec_w[i][5];
        derr_d[i]       = dec_w[i][6];
      end
    end
  end

  // Decode output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q    <= '0;
      points_q <= '0;
      blank_q  <= '0;
      derr_q   <= '0;
    end else begin
      hex_q    <= hex_d;
      points_q <= points_d;
      blank_q  <= blank_d;
      derr_q   <= derr_d;
    end
  end

  assign hex        = hex_q;
  assign points     = points_q;
  assign blank      = blank_q;
  assign decode_err = derr_q;
`else
  assign hex        = '0;
  assign points     = '0;
  assign blank      = '0;
  assign decode_err = '0;
`endif

endmodule

// File: tb/tb_sseg_s2p_rx.sv
// Directed testbench for sseg_s2p_rx (SYNC_STAGES = 2).
// Decode expectations collapse to 0 when SSEG_RX_DECODE_EN is not defined.
module tb_sseg_s2p_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        seg_clk;
  logic        seg_clrn;
  logic        SEG_PEN;
  logic        seg_sout;
  logic [63:0] frame;
  logic        frame_valid;
  logic        frame_err;
  logic [31:0] hex;
  logic [7:0]  points;
  logic [7:0]  blank;
  logic [7:0]  decode_err;

  int checks   = 0;
  int failures = 0;
  int nv       = 0;
  int ne       = 0;

  // Frame F1 is digits 1..8 with all decimal points off.
  localparam logic [63:0] F1 = 64'hF9A4B0999282F880;
  // Frame F2: byte7 = 00 (glyph 8, dp on), byte0 = 7F (blank, dp on), the rest glyph 0.
  localparam logic [63:0] F2 = 64'h00C0C0C0C0C0C07F;
  // Frame F4 is an arbitrary pattern, checked as raw frame bits only.
  localparam logic [63:0] F4 = 64'h0123456789ABCDEF;
  // Frame F6 is F1 with byte 3 replaced by the non-glyph value AA.
  localparam logic [63:0] F6 = 64'hF9A4B099AA82F880;

  always #5 clk = ~clk;

  sseg_s2p_rx #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_clk    (seg_clk),
    .seg_clrn   (seg_clrn),
    .SEG_PEN    (SEG_PEN),
    .seg_sout   (seg_sout),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .hex        (hex),
    .points     (points),
    .blank      (blank),
    .decode_err (decode_err)
  );

  always @(posedge clk) begin
    if (frame_valid) nv <= nv + 1;
    if (frame_err)   ne <= ne + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dec(input string tag, input logic [31:0] eh, input logic [7:0] ep,
                           input logic [7:0] eb, input logic [7:0] ed);
`ifndef SSEG_RX_DECODE_EN
    eh = '0;
    ep = '0;
    eb = '0;
    ed = '0;
`endif
    check_eq({tag, "_hex"},    64'(hex),        64'(eh));
    check_eq({tag, "_points"}, 64'(points),     64'(ep));
    check_eq({tag, "_blank"},  64'(blank),      64'(eb));
    check_eq({tag, "_derr"},   64'(decode_err), 64'(ed));
  endtask

  // Sends data[n-1] first, down to data[0].
  task automatic shift_bits(input logic [63:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      seg_sout = data[i];
      repeat (2) @(negedge clk);
      seg_clk = 1'b1;
      repeat (4) @(negedge clk);
      seg_clk = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // Raises SEG_PEN and checks the pulse type, its 3-cycle latency and its 1-cycle width.
  task automatic end_frame(input string tag, input bit expect_valid);
    int  k;
    bit  seen;
    repeat (2) @(negedge clk);
    SEG_PEN = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 10) begin
      @(posedge clk);
      #1;
      k++;
      if (frame_valid || frame_err) seen = 1'b1;
    end
    check_eq({tag, "_lat"},   64'(k), 64'd3);
    check_eq({tag, "_valid"}, 64'(frame_valid), 64'(expect_valid));
    check_eq({tag, "_err"},   64'(frame_err), 64'(!expect_valid));
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse1"}, 64'({frame_valid, frame_err}), 64'd0);
    @(negedge clk);
    SEG_PEN = 1'b0;
    repeat (4) @(negedge clk);
    $display("txn %s: frame=%h hex=%h points=%h blank=%h derr=%h", tag, frame, hex, points,
             blank, decode_err);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_frame"}, frame, 64'd0);
    check_eq({tag, "_pulses"}, 64'({frame_valid, frame_err}), 64'd0);
    check_eq({tag, "_dec"}, 64'({hex, points, blank, decode_err}), 64'd0);
  endtask

  initial begin
    int nv0;
    int ne0;
    rst      = 1'b1;
    seg_clk  = 1'b0;
    seg_clrn = 1'b1;
    SEG_PEN  = 1'b1;
    seg_sout = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    SEG_PEN = 1'b0;
    repeat (4) @(negedge clk);

    // Full frame with digits 1..8.
    shift_bits(F1, 64);
    end_frame("t1", 1'b1);
    check_eq("t1_frame", frame, F1);
    check_dec("t1", 32'h12345678, 8'h00, 8'h00, 8'h00);

    // Blank digit 0 and glyph 8 with dp on digit 7.
    shift_bits(F2, 64);
    end_frame("t2", 1'b1);
    check_eq("t2_frame", frame, F2);
    check_dec("t2", 32'h80000000, 8'h81, 8'h01, 8'h00);

    // A 63-bit short frame reports an error and holds the prior frame.
    shift_bits(F1, 63);
    end_frame("t3", 1'b0);
    check_eq("t3_frame", frame, F2);
    check_dec("t3", 32'h80000000, 8'h81, 8'h01, 8'h00);

    // A partial frame is cleared by seg_clrn, then a full frame is sent.
    shift_bits(64'h2AAAAAAA, 30);
    @(negedge clk);
    seg_clrn = 1'b0;
    repeat (4) @(negedge clk);
    seg_clrn = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits(F4, 64);
    end_frame("t4", 1'b1);
    check_eq("t4_frame", frame, F4);

    // Reset mid-frame after 40 bits, then send one clean frame.
    shift_bits(F2, 40);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("t5_rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("t5_post");
    nv0 = nv;
    ne0 = ne;
    shift_bits(F1, 64);
    end_frame("t5", 1'b1);
    check_eq("t5_frame", frame, F1);
    check_eq("t5_nvalid", 64'(nv - nv0), 64'd1);
    check_eq("t5_nerr", 64'(ne - ne0), 64'd0);
    check_dec("t5", 32'h12345678, 8'h00, 8'h00, 8'h00);

    // Non-glyph byte 3.
    shift_bits(F6, 64);
    end_frame("t6", 1'b1);
    check_eq("t6_frame", frame, F6);
    check_dec("t6", 32'h12340678, 8'h00, 8'h00, 8'h08);

    // seg_clk edges while SEG_PEN is high must not count toward the next frame.
    // Raising SEG_PEN with an empty chain yields one error pulse.
    @(negedge clk);
    SEG_PEN = 1'b1;
    repeat (6) @(negedge clk);
    shift_bits(F1, 5);
    SEG_PEN = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(F2, 64);
    end_frame("t7", 1'b1);
    check_eq("t7_frame", frame, F2);
    check_dec("t7", 32'h80000000, 8'h81, 8'h01, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bounds the run in case the stimulus stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
